// File: rtl/cordic_vector_if.sv
// cordic_vector_if: valid/ready input and output handshakes of the vectoring CORDIC
interface cordic_vector_if #(parameter int DATA_WIDTH = 8);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic in_valid;
  logic in_ready;
  logic signed [DATA_WIDTH-1:0] angle_out;
  logic [DATA_WIDTH-1:0] mag_out;
  logic out_valid;
  logic out_ready;
  modport master (output x_in, y_in, in_valid, out_ready, input in_ready, angle_out, mag_out, out_valid);
  modport slave (input x_in, y_in, in_valid, out_ready, output in_ready, angle_out, mag_out, out_valid);
endinterface

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring CORDIC returning atan2(y, x) in units of pi and the gain-corrected magnitude
module cordic_vector #(
  parameter int DATA_WIDTH = 8,
  parameter int ITER_COUNT = 12
) (
  input logic clk,
  input logic rst,
  cordic_vector_if.slave bus_io
);
  localparam int IW = DATA_WIDTH + 8;
  localparam int ZS = 15 - DATA_WIDTH;
  localparam logic signed [16:0] AMAX = 17'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [16:0] AMIN = -AMAX - 17'sd1;
  localparam int MMAX = 2 ** DATA_WIDTH - 1;
  localparam logic signed [15:0] ATAN [16] = '{
    16'sd4096, 16'sd2418, 16'sd1278, 16'sd649, 16'sd326, 16'sd163, 16'sd81, 16'sd41,
    16'sd20, 16'sd10, 16'sd5, 16'sd3, 16'sd1, 16'sd1, 16'sd0, 16'sd0
  };
  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;
  state_t state_q, state_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, dx, dy;
  logic signed [15:0] z_q, z_d;
  logic [3:0] i_q, i_d;
  logic zero_q, zero_d;
  logic signed [DATA_WIDTH-1:0] angle_q, angle_d, a_sat;
  logic [DATA_WIDTH-1:0] mag_q, mag_d, m_sat;
  logic signed [16:0] a_full;
  logic signed [31:0] m_full;
  logic neg;
  assign neg = y_q[IW-1];
  assign dx = x_q >>> i_q;
  assign dy = y_q >>> i_q;
  assign a_full = (17'(z_q) + 17'(2 ** (ZS - 1))) >>> ZS;
  assign a_sat = (a_full > AMAX) ? DATA_WIDTH'(AMAX) : (a_full < AMIN) ? DATA_WIDTH'(AMIN) : a_full[DATA_WIDTH-1:0];
  assign m_full = (32'(x_q) * 32'sd2487 + 32'sd131072) >>> 18;
  assign m_sat = (m_full > MMAX) ? DATA_WIDTH'(MMAX) : (m_full < 0) ? '0 : m_full[DATA_WIDTH-1:0];
  assign bus_io.in_ready = state_q == IDLE;
  assign bus_io.out_valid = state_q == DONE;
  assign bus_io.angle_out = angle_q;
  assign bus_io.mag_out = mag_q;
  // next state: capture, quadrant fold into the right half-plane, micro-rotations, then rounding and gain removal
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    zero_d = zero_q;
    angle_d = angle_q;
    mag_d = mag_q;
    unique case (state_q)
      IDLE: if (bus_io.in_valid) begin
        x_d = IW'(bus_io.x_in) <<< 6;
        y_d = IW'(bus_io.y_in) <<< 6;
        zero_d = (bus_io.x_in == '0) && (bus_io.y_in == '0);
        state_d = PRE;
      end
      PRE: begin
        x_d = !x_q[IW-1] ? x_q : neg ? -y_q : y_q;
        y_d = !x_q[IW-1] ? y_q : neg ? x_q : -x_q;
        z_d = !x_q[IW-1] ? 16'sd0 : neg ? -16'sd8192 : 16'sd8192;
        i_d = '0;
        state_d = ITER;
      end
      ITER: begin
        x_d = neg ? x_q - dy : x_q + dy;
        y_d = neg ? y_q + dx : y_q - dx;
        z_d = neg ? z_q - ATAN[i_q] : z_q + ATAN[i_q];
        i_d = i_q + 4'd1;
        state_d = (i_q == 4'(ITER_COUNT - 1)) ? SCALE : ITER;
      end
      SCALE: begin
        angle_d = zero_q ? '0 : a_sat;
        mag_d = zero_q ? '0 : m_sat;
        state_d = DONE;
      end
      DONE: state_d = bus_io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset returns to IDLE with everything cleared
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
      zero_q <= 1'b0;
      angle_q <= '0;
      mag_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      zero_q <= zero_d;
      angle_q <= angle_d;
      mag_q <= mag_d;
    end
  end
endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: scoreboard bench comparing the vectoring CORDIC against floating-point atan2/hypot
module tb_cordic_vector;
  localparam int DW = 8;
  localparam int IC = 12;
  localparam real PI = 3.14159265358979323846;
  typedef struct { int x; int y; int a; int m; } exp_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  cordic_vector_if #(.DATA_WIDTH(DW)) bus ();
  cordic_vector #(.DATA_WIDTH(DW), .ITER_COUNT(IC)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  exp_t exp_q[$];
  int acc_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_acc_prev = 0;
  logic rdy_fix = 1, rnd_en = 0, rnd_bit = 1;
  assign bus.out_ready = rnd_en ? rnd_bit : rdy_fix;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end
  function automatic void chk(string name, int act, int exp, int tol);
    n_vec++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endfunction
  function automatic exp_t model(int x, int y);
    exp_t e;
    real th;
    e.x = x;
    e.y = y;
    th = (x == 0 && y == 0) ? 0.0 : $atan2(real'(y), real'(x));
    e.a = int'($floor(th / PI * 128.0 + 0.5));
    if (e.a > 127) e.a = 127;
    if (e.a < -128) e.a = -128;
    e.m = int'($floor($sqrt(real'(x * x + y * y)) + 0.5));
    if (e.m > 255) e.m = 255;
    return e;
  endfunction
  task automatic send(input int x, input int y, input bit hold, input bit keep);
    int n = 0;
    bus.x_in = DW'(x);
    bus.y_in = DW'(y);
    bus.in_valid = 1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1, 0);
      bus.in_valid = 0;
      return;
    end
    if (keep) exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    last_acc_prev = last_acc;
    last_acc = cyc;
    if (keep) acc_q.push_back(cyc);
    if (!hold) bus.in_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0, 0);
  endtask
  task automatic rnd_xy(output int x, output int y);
    do begin
      x = int'($urandom_range(0, 255)) - 128;
      y = int'($urandom_range(0, 255)) - 128;
    end while ((x < 0 ? -x : x) + (y < 0 ? -y : y) < 16);
  endtask
  logic prev_v = 0;
  int prev_a = 0, prev_m = 0;
  always @(negedge clk) begin
    exp_t e;
    int tol;
    if (rst) begin
      if (bus.out_valid && !prev_v) begin
        if (acc_q.size() == 0) chk("unexpected_valid", 1, 0, 0);
        else chk("latency", cyc - acc_q.pop_front(), IC + 2, 0);
      end
      if (bus.out_valid && prev_v) begin
        chk("hold_angle", int'(bus.angle_out), prev_a, 0);
        chk("hold_mag", int'(bus.mag_out), prev_m, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0, 0);
        else begin
          e = exp_q.pop_front();
          tol = (e.x == 0 && e.y == 0) ? 0 : 1;
          chk($sformatf("angle(%0d,%0d)", e.x, e.y), int'(bus.angle_out), e.a, tol);
          chk($sformatf("mag(%0d,%0d)", e.x, e.y), int'(bus.mag_out), e.m, tol);
        end
      end
      prev_v = bus.out_valid;
      prev_a = int'(bus.angle_out);
      prev_m = int'(bus.mag_out);
    end else prev_v = 0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int dx[7] = '{64, 0, 64, 0, -128, -64, 0};
    int dy[7] = '{0, 64, 64, -64, -128, 0, 0};
    int x, y, n;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1, 0);
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_angle", int'(bus.angle_out), 0, 0);
    chk("rst_mag", int'(bus.mag_out), 0, 0);
    rst = 1;
    for (int k = 0; k < 7; k++) send(dx[k], dy[k], 0, 1);
    wait_idle();
    rdy_fix = 0;
    send(40, -70, 0, 1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", int'(bus.out_valid), 1, 0);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", int'(bus.in_ready), 0, 0);
      chk("bp_out_valid", int'(bus.out_valid), 1, 0);
    end
    rdy_fix = 1;
    @(posedge clk);
    #1;
    chk("post_hs_in_ready", int'(bus.in_ready), 1, 0);
    chk("post_hs_out_valid", int'(bus.out_valid), 0, 0);
    send(100, 20, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", int'(bus.in_ready), 1, 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0, 0);
    chk("midrst_angle", int'(bus.angle_out), 0, 0);
    chk("midrst_mag", int'(bus.mag_out), 0, 0);
    rst = 1;
    send(32, 32, 0, 1);
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      rnd_xy(x, y);
      send(x, y, k < 3, 1);
      if (k > 0) chk("b2b_spacing", last_acc - last_acc_prev, IC + 4, 0);
    end
    wait_idle();
    rnd_en = 1;
    for (int k = 0; k < 40; k++) begin
      rnd_xy(x, y);
      send(x, y, 0, 1);
    end
    wait_idle();
    rnd_en = 0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
